// File: rtl/bec_pkg.sv
// Shared constants and types for the BEC affine-conversion datapath.
// GF(2^163) polynomial basis, f(x) = x^163 + x^7 + x^6 + x^3 + 1.
package bec_pkg;

   localparam int M = 163;
   localparam logic [M-1:0] POLY_LOW = 163'hC9;
   localparam logic [M:0]   F = {1'b1, POLY_LOW};

   // Each halving lowers deg(a)+deg(b) by one and every add is followed by a halving.
   localparam int MAX_DIV_CYCLES = 2 * (2 * M);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   function automatic logic is_one(input logic [M:0] val);
      return val == {{M{1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/bec_affine_conv_if.sv
// Request/result bundle between the scalar-multiplication core side and the affine converter.
interface bec_affine_conv_if;
   import bec_pkg::*;

   logic         start;
   logic [M-1:0] w_in;
   logic [M-1:0] z_in;
   logic         busy;
   logic         done;
   logic         div_zero;
   logic [M-1:0] x_out;

   modport master (
      output start, w_in, z_in,
      input  busy, done, div_zero, x_out
   );

   modport slave (
      input  start, w_in, z_in,
      output busy, done, div_zero, x_out
   );

endinterface

// File: rtl/gf2m_half.sv
// Combinational divide-by-x modulo f: adds f first when the operand is odd so the shift is exact.
module gf2m_half
   import bec_pkg::*;
(
   input  logic [M-1:0] u,
   output logic [M-1:0] y
);

   // (({0,u} ^ F) >> 1) splits into (u >> 1) ^ (F >> 1); F[0] cancels u[0].
   localparam logic [M-1:0] F_HALF = F[M:1];

   logic [M-1:0] u_shr;

   assign u_shr = {1'b0, u[M-1:1]};
   assign y     = u[0] ? (u_shr ^ F_HALF) : u_shr;

endmodule

// File: rtl/bec_affine_conv.sv
// Projective-to-affine conversion x = W / Z in GF(2^163) using a binary-Euclid divider,
// one reduction step per clock.
module bec_affine_conv
   import bec_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   bec_affine_conv_if.slave bus
);

   state_t state, state_nxt;

   logic [M:0]   a, a_nxt;
   logic [M:0]   b, b_nxt;
   logic [M-1:0] u, u_nxt;
   logic [M-1:0] v, v_nxt;
   logic [M-1:0] x_q, x_nxt;
   logic         dz_q, dz_nxt;
   logic         armed;

   logic [M-1:0] u_half;
   logic [M-1:0] v_half;

   gf2m_half u_half_u (
      .u (u),
      .y (u_half)
   );

   gf2m_half u_half_v (
      .u (v),
      .y (v_half)
   );

   // NOTE: state and datapath registers use non-blocking assignments so every register
   // samples the pre-edge values computed by the combinational block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a     <= '0;
         b     <= '0;
         u     <= '0;
         v     <= '0;
         x_q   <= '0;
         dz_q  <= 1'b0;
         armed <= 1'b0;
      end else begin
         state <= state_nxt;
         a     <= a_nxt;
         b     <= b_nxt;
         u     <= u_nxt;
         v     <= v_nxt;
         x_q   <= x_nxt;
         dz_q  <= dz_nxt;
         armed <= 1'b1;
      end
   end

   // armed stays low for the first edge after reset release, so a start that coincides
   // with deassertion is never accepted.
   always_comb begin
      // NOTE: every target gets a hold-value default first; a path that skips an
      // assignment would otherwise infer a latch.
      state_nxt = state;
      a_nxt     = a;
      b_nxt     = b;
      u_nxt     = u;
      v_nxt     = v;
      x_nxt     = x_q;
      dz_nxt    = dz_q;

      case (state)
         RUN: begin
            if (is_one(a)) begin
               x_nxt     = u;
               dz_nxt    = 1'b0;
               state_nxt = DONE;
            end else if (is_one(b)) begin
               x_nxt     = v;
               dz_nxt    = 1'b0;
               state_nxt = DONE;
            end else if (!a[0]) begin
               a_nxt = a >> 1;
               u_nxt = u_half;
            end else if (!b[0]) begin
               b_nxt = b >> 1;
               v_nxt = v_half;
            end else if (a > b) begin
               a_nxt = a ^ b;
               u_nxt = u ^ v;
            end else begin
               b_nxt = b ^ a;
               v_nxt = v ^ u;
            end
         end

         DONE: begin
            state_nxt = IDLE;
         end

         // IDLE and the unreachable 2'b11 encoding share this branch.
         default: begin
            if (bus.start && armed) begin
               if (bus.z_in != '0) begin
                  a_nxt     = {1'b0, bus.z_in};
                  b_nxt     = F;
                  u_nxt     = bus.w_in;
                  v_nxt     = '0;
                  state_nxt = RUN;
               end else begin
                  x_nxt     = '0;
                  dz_nxt    = 1'b1;
                  state_nxt = DONE;
               end
            end
         end
      endcase
   end

   // div_zero travels with x_out: both change only when entering DONE.
   assign bus.busy     = (state == RUN) || (state == DONE);
   assign bus.done     = (state == DONE);
   assign bus.x_out    = x_q;
   assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_bec_affine_conv.sv
// Directed and randomized bench for bec_affine_conv; results checked by GF(2^163) multiplication.
module tb_bec_affine_conv;
   import bec_pkg::*;

   localparam int LAT_BOUND = MAX_DIV_CYCLES + 8;
   localparam int N_RANDOM  = 60;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   bec_affine_conv_if bus ();

   bec_affine_conv dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [M:0] obs, input logic [M:0] want);
      checks++;
      assert (obs === want)
      else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask

   function automatic logic [M:0] ext1(input logic val);
      return {{M{1'b0}}, val};
   endfunction

   function automatic logic [M:0] ext(input logic [M-1:0] val);
      return {1'b0, val};
   endfunction

   function automatic logic [M:0] exti(input int val);
      logic [31:0] w32;
      w32 = val;
      return {{(M-31){1'b0}}, w32};
   endfunction

   // Schoolbook multiply with interleaved reduction by f.
   function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
      logic [M:0] acc;
      acc = '0;
      for (int i = M - 1; i >= 0; i--) begin
         acc = acc << 1;
         if (acc[M]) acc = acc ^ F;
         if (y[i]) acc = acc ^ {1'b0, x};
      end
      return acc[M-1:0];
   endfunction

   function automatic logic [M-1:0] rand_elem();
      logic [191:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (r[M-1:0] == '0) r[0] = 1'b1;
      return r[M-1:0];
   endfunction

   // Runs one operation; lat counts cycles from acceptance to the cycle done is seen.
   task automatic do_op(input logic [M-1:0] w, input logic [M-1:0] z, input int inj_at,
                        input logic [M-1:0] w2, input logic [M-1:0] z2,
                        output logic [M-1:0] x, output logic dz, output int lat,
                        output logic busy_ok, output logic pulse_ok);
      @(negedge clk);
      bus.start = 1'b1;
      bus.w_in  = w;
      bus.z_in  = z;
      @(negedge clk);
      bus.start = 1'b0;
      lat       = 1;
      busy_ok   = 1'b1;
      while (bus.done !== 1'b1 && lat < LAT_BOUND) begin
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
         if (lat == inj_at) begin
            bus.start = 1'b1;
            bus.w_in  = w2;
            bus.z_in  = z2;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      bus.start = 1'b0;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      x  = bus.x_out;
      dz = bus.div_zero;
      @(negedge clk);
      pulse_ok = (bus.done === 1'b0) && (bus.busy === 1'b0) &&
                 (bus.x_out === x) && (bus.div_zero === dz);
   endtask

   initial begin
      logic [M-1:0] x, w, z, w2, z2;
      logic         dz, busy_ok, pulse_ok;
      int           lat;

      bus.start = 1'b0;
      bus.w_in  = '0;
      bus.z_in  = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", ext1(bus.busy), ext1(1'b0));
      check("rst_done", ext1(bus.done), ext1(1'b0));
      check("rst_div_zero", ext1(bus.div_zero), ext1(1'b0));
      check("rst_x_out", ext(bus.x_out), ext('0));

      // Start coincident with reset release must be ignored
      bus.start = 1'b1;
      bus.w_in  = 163'h5;
      bus.z_in  = 163'h1;
      rst_n     = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("start_at_release_busy", ext1(bus.busy), ext1(1'b0));
      @(negedge clk);
      check("start_at_release_done", ext1(bus.done), ext1(1'b0));

      // Z == 1: done two cycles after acceptance, result is W
      do_op(163'h1234, 163'h1, 0, '0, '0, x, dz, lat, busy_ok, pulse_ok);
      check("z1_latency", exti(lat), exti(2));
      check("z1_x_out", ext(x), ext(163'h1234));
      check("z1_div_zero", ext1(dz), ext1(1'b0));
      check("z1_busy", ext1(busy_ok), ext1(1'b1));

      // 1 / x = x^162 + x^6 + x^5 + x^2
      w = '0;
      w[162] = 1'b1;
      w[6:0] = 7'h64;
      do_op(163'h1, 163'h2, 0, '0, '0, x, dz, lat, busy_ok, pulse_ok);
      check("inv_x_x_out", ext(x), ext(w));
      check("inv_x_single_pulse", ext1(pulse_ok), ext1(1'b1));

      // Division by zero
      do_op(rand_elem(), '0, 0, '0, '0, x, dz, lat, busy_ok, pulse_ok);
      check("z0_latency", exti(lat), exti(1));
      check("z0_div_zero", ext1(dz), ext1(1'b1));
      check("z0_x_out", ext(x), ext('0));
      check("z0_pulse", ext1(pulse_ok), ext1(1'b1));

      // Recovery after div-by-zero: 3 / 3 = 1
      do_op(163'h3, 163'h3, 0, '0, '0, x, dz, lat, busy_ok, pulse_ok);
      check("three_x_out", ext(x), ext(163'h1));
      check("three_div_zero", ext1(dz), ext1(1'b0));

      // Zero dividend
      do_op('0, rand_elem(), 0, '0, '0, x, dz, lat, busy_ok, pulse_ok);
      check("w0_x_out", ext(x), ext('0));
      check("w0_div_zero", ext1(dz), ext1(1'b0));

      // Random nonzero operands against the multiplicative identity x*Z == W
      for (int n = 0; n < N_RANDOM; n++) begin
         w = rand_elem();
         z = rand_elem();
         do_op(w, z, 0, '0, '0, x, dz, lat, busy_ok, pulse_ok);
         check("rand_product", ext(gf_mul(x, z)), ext(w));
         check("rand_div_zero", ext1(dz), ext1(1'b0));
         check("rand_run_cycles_ok", ext1((lat - 1) <= MAX_DIV_CYCLES), ext1(1'b1));
         check("rand_busy", ext1(busy_ok), ext1(1'b1));
         check("rand_pulse", ext1(pulse_ok), ext1(1'b1));
      end

      // Start reasserted mid-RUN with other operands is ignored
      w  = rand_elem();
      z  = rand_elem();
      w2 = rand_elem();
      z2 = rand_elem();
      do_op(w, z, 5, w2, z2, x, dz, lat, busy_ok, pulse_ok);
      check("midrun_start_product", ext(gf_mul(x, z)), ext(w));
      check("midrun_start_busy", ext1(busy_ok), ext1(1'b1));

      // Asynchronous reset at cycle 100 of a long division (Z = x^162)
      w = rand_elem();
      z = '0;
      z[162] = 1'b1;
      @(negedge clk);
      bus.start = 1'b1;
      bus.w_in  = w;
      bus.z_in  = z;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (99) @(negedge clk);
      check("pre_reset_busy", ext1(bus.busy), ext1(1'b1));
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_busy", ext1(bus.busy), ext1(1'b0));
      check("async_rst_done", ext1(bus.done), ext1(1'b0));
      check("async_rst_div_zero", ext1(bus.div_zero), ext1(1'b0));
      check("async_rst_x_out", ext(bus.x_out), ext('0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Fresh operation after reset: 162 halvings, then a == 1
      do_op(w, z, 0, '0, '0, x, dz, lat, busy_ok, pulse_ok);
      check("post_rst_product", ext(gf_mul(x, z)), ext(w));
      check("post_rst_latency", exti(lat), exti(164));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
